seq_restoring_div_2n_n: RTL
===========================

// Module: seq_restoring_div_2n_n
// PURPOSE
//  Multi-cycle unsigned restoring divider. Inverse datapath of the GenMul 2N-bit product generators.
//  Divides a 2N-bit dividend (a multiplier product) by an N-bit divisor. Returns a 2N-bit quotient and an N-bit remainder.
//  Sits after the DT/RC multipliers in the verification harness: out = P / IN2 recovers IN1 on an exact product.
//  On an approximate product, the non-zero remainder and quotient error expose the approximation error.
// PARAMETERS
//  N        8   divisor width; dividend and quotient are 2N bits
//  CNT_W    $clog2(2*N+1)   iteration counter width (derived localparam, not overridable)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  in_valid   in   1     dividend/divisor present
//  in_ready   out  1     divider can accept an operand pair
//  dividend   in   2N    unsigned dividend
//  divisor    in   N     unsigned divisor
//  out_valid  out  1     result held on the output ports
//  out_ready  in   1     consumer accepts the result
//  quotient   out  2N    unsigned quotient
//  remainder  out  N     unsigned remainder, always < divisor when divisor != 0
//  div_zero   out  1     result was produced with divisor == 0
// BEHAVIOUR
//  Reset values (async, immediate): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, counter=0.
//  Handshake: a transfer occurs on a rising edge where valid&ready are both 1. Inputs are sampled only on that edge.
//  FSM:
//   IDLE -> CALC  on an in transfer with divisor!=0. Loads the quotient shift register with dividend, the partial remainder (N+1 bits) with 0, and the counter with 2N.
//   IDLE -> DONE  on an in transfer with divisor==0. quotient={2N{1'b1}}, remainder=dividend[N-1:0], div_zero=1.
//   CALC: each cycle is one restoring step.
//    r' = {r[N-1:0], q[2N-1]}; q shifted left.
//    if r' >= {1'b0,divisor}: r = r' - divisor and q[0]=1; else r = r' and q[0]=0.
//    The counter decrements each step. On the step where counter==1 -> DONE.
//   DONE: out_valid=1, outputs stable. On an out transfer -> IDLE.
//  in_ready=1 only in IDLE; no overlap between operations (throughput 1 op / 2N+2 cycles minimum).
//  Latency: in transfer at edge E -> out_valid=1 after edge E+2N (16 cycles for N=8). Divide-by-zero: out_valid after edge E+1.
//  Output registers are written only on the CALC->DONE and IDLE->DONE transitions.
//  Outputs stay constant while out_valid=1 and out_ready=0, with unlimited backpressure.
//  When out_valid=0, quotient, remainder and div_zero hold the last result and carry no meaning.
//  Width rule: the partial remainder is N+1 bits so the compare never overflows. The remainder output is r[N-1:0].
//  in_valid in CALC/DONE is ignored (in_ready=0). Producers must hold the operands until accepted.
//  Reset mid-CALC or mid-DONE aborts the operation: no out_valid pulse, and the next op starts cleanly from IDLE.
//  No X propagation: every register has a reset value and the FSM has a default -> IDLE.
// STRUCTURE
//  Shared package div_pkg: state enum {IDLE, CALC, DONE}, DIV_N default localparam, and the divide-by-zero quotient constant.
//  One sub-module: div_restore_step (combinational): inputs r, q_msb, divisor; outputs r_next, q_bit.
//  The top holds the FSM, counter, shift registers and output registers.
// TESTING
//  1. 65025 / 255 -> quotient=255, remainder=0, div_zero=0, out_valid exactly 16 cycles after accept.
//  2. 1000 / 7 -> quotient=142, remainder=6; then 65535 / 1 -> quotient=65535, remainder=0.
//  3. 1234 / 0 -> quotient=16'hFFFF, remainder=8'hD2, div_zero=1, out_valid 1 cycle after accept.
//  4. Hold out_ready=0 for 20 cycles after 300/17 -> q=17, r=11 stable throughout, in_ready=0. Then release out_ready -> back to IDLE, in_ready=1.
//  5. Assert rst at CALC cycle 7 of 5000/3 -> all outputs reset, no out_valid. Then 5000/3 -> q=1666, r=2.
//  6. Random sweep of all 8x8 exact products a*b, b!=0 -> quotient==a, remainder==0. Approximate DT product / b -> compare against the golden model.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared types and constants for the sequential restoring divider
//             (FSM state encoding, default divisor width, divide-by-zero
//             quotient pattern).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default divisor width; dividend and quotient are twice this
    localparam int DIV_N = 8;

    // Quotient reported for a zero divisor: all ones. Held 64 bits wide so any
    // supported quotient width (2N <= 64) can take a slice of it.
    localparam logic [63:0] c_div0_quotient = '1;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_restore_step
//  Purpose  : One combinational restoring-division step. Shifts the next
//             dividend bit into the partial remainder and subtracts the
//             divisor when it fits.
//  Ports    : r       in  N+1  current partial remainder
//             q_msb   in  1    dividend bit shifted in this step
//             divisor in  N    divisor
//             r_next  out N+1  updated partial remainder
//             q_bit   out 1    quotient bit produced by this step
//  Revision : 1.0 - initial release
// ============================================================================
module div_restore_step #(
    parameter int N = 8
) (
    input  logic [N:0]   r,
    input  logic         q_msb,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_next,
    output logic         q_bit
);

    // The partial remainder is always below the divisor, so r[N] is zero and
    // {r, q_msb} equals the N+1-bit shifted value {r[N-1:0], q_msb}. Using the
    // full vector keeps the compare exact without discarding any input bit.
    logic [N+1:0] w_shift;
    logic [N+1:0] w_div_ext;

    assign w_shift   = {r, q_msb};
    assign w_div_ext = {2'b00, divisor};
    assign q_bit     = (w_shift >= w_div_ext);
    assign r_next    = q_bit ? (N+1)'(w_shift - w_div_ext) : (N+1)'(w_shift);

endmodule : div_restore_step
`default_nettype wire

// File: rtl/seq_restoring_div_2n_n.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_div_2n_n
//  Purpose  : Multi-cycle unsigned restoring divider, 2N-bit dividend by
//             N-bit divisor, one quotient bit per clock. Valid/ready
//             handshakes on both sides; one operation in flight at a time.
//  Ports    : clk        in   1   rising-edge clock
//             rst        in   1   asynchronous active-high reset
//             in_valid   in   1   operand pair present
//             in_ready   out  1   divider idle, can accept operands
//             dividend   in   2N  unsigned dividend
//             divisor    in   N   unsigned divisor
//             out_valid  out  1   result held on the outputs
//             out_ready  in   1   consumer accepts the result
//             quotient   out  2N  unsigned quotient (all ones on div-by-zero)
//             remainder  out  N   unsigned remainder (dividend[N-1:0] on
//                                 div-by-zero)
//             div_zero   out  1   result produced with a zero divisor
//  Revision : 1.0 - initial release
// ============================================================================
module seq_restoring_div_2n_n
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero
);

    localparam int               CNT_W      = $clog2(2*N+1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(2*N);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(1);

    state_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2*N-1:0] r_q;        // dividend bits shift out, quotient bits in
    logic [N:0]     r_rem;      // partial remainder, one guard bit
    logic [N-1:0]   r_divisor;  // divisor captured at accept

    logic [N:0]     w_r_next;
    logic           w_q_bit;

    div_restore_step #(
        .N (N)
    ) u_step (
        .r       (r_rem),
        .q_msb   (r_q[2*N-1]),
        .divisor (r_divisor),
        .r_next  (w_r_next),
        .q_bit   (w_q_bit)
    );

    // Handshake flags decode straight from the state register
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor != '0) begin
                            r_q       <= dividend;
                            r_rem     <= '0;
                            r_divisor <= divisor;
                            r_cnt     <= c_cnt_load;
                            r_state   <= CALC;
                        end else begin
                            // Zero divisor: answer immediately, no iterations
                            quotient  <= c_div0_quotient[2*N-1:0];
                            remainder <= dividend[N-1:0];
                            div_zero  <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end

                CALC: begin
                    r_q   <= {r_q[2*N-2:0], w_q_bit};
                    r_rem <= w_r_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == c_cnt_last) begin
                        // Last step: publish this step's result directly
                        quotient  <= {r_q[2*N-2:0], w_q_bit};
                        remainder <= w_r_next[N-1:0];
                        div_zero  <= 1'b0;
                        r_state   <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : seq_restoring_div_2n_n
`default_nettype wire
